// File: rtl/filter_pkg.sv
// Shared types and constants for the BPM-driven pixel filter bank.
package filter_pkg;

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    THRESH = 2'd1,
    BRIGHT = 2'd2,
    INVERT = 2'd3
  } filter_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } frame_state_e;

  localparam int CNT_W = 32;

endpackage

// File: rtl/pixel_filter_lane.sv
// One colour channel of the filter bank: purely combinational per-pixel arithmetic.
module pixel_filter_lane
  import filter_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] pix,
  input  logic [DATA_W-1:0] level,
  input  logic [1:0]        mode,
  input  logic              en,
  output logic [DATA_W-1:0] out
);

  // One extra bit so the blend sum never wraps before the halving shift.
  logic [DATA_W:0] sum;

  always_comb begin
    sum = {1'b0, pix} + {1'b0, level};
    out = pix;
    if (en) begin
      case (mode)
        THRESH:  out = (pix >= level) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
        BRIGHT:  out = DATA_W'(sum >> 1);
        INVERT:  out = ~pix;
        default: out = pix;
      endcase
    end
  end

endmodule

// File: rtl/bpm_pixel_filter_bank.sv
// Two-stage ready/valid pixel filter whose per-frame level tracks a BPM estimate.
module bpm_pixel_filter_bank
  import filter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int BPM_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS*DATA_W-1:0]   s_pix,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         s_sof,
  input  logic [1:0]                   mode,
  input  logic                         filter_enable,
  input  logic [BPM_W-1:0]             bpm_estimate,
  output logic [CHANNELS*DATA_W-1:0]   m_pix,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_sof,
  output logic [DATA_W-1:0]            level,
  output logic [CNT_W-1:0]             frame_pixels,
  output logic                         frame_state
);

  // Handshake: a beat moves on an interface only at a rising clk edge where
  // valid and ready are both high; valid never waits on ready.

  localparam int EW = (BPM_W > DATA_W) ? BPM_W : DATA_W;

  frame_state_e state_q, state_d;

  logic                       s1_valid;
  logic                       s1_sof;
  logic [CHANNELS*DATA_W-1:0] s1_pix;
  logic [1:0]                 s1_mode;
  logic                       s1_en;
  logic [DATA_W-1:0]          s1_level;

  logic [1:0]                 cfg_mode;
  logic                       cfg_en;
  logic [CNT_W-1:0]           beat_cnt;

  logic                       s_fire;
  logic                       s1_adv;
  logic                       m_fire;
  logic [EW-1:0]              bpm_ext;
  logic [DATA_W-1:0]          sat_level;
  logic [1:0]                 beat_mode;
  logic                       beat_en;
  logic [DATA_W-1:0]          beat_level;
  logic [CHANNELS*DATA_W-1:0] lane_out;

  assign s1_adv      = s1_valid && (m_ready || !m_valid);
  assign s_ready     = !s1_valid || s1_adv;
  assign s_fire      = s_valid && s_ready;
  assign m_fire      = m_valid && m_ready;
  assign frame_state = (state_q == ACTIVE);

  assign bpm_ext   = EW'(bpm_estimate);
  assign sat_level = (bpm_ext > EW'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : bpm_ext[DATA_W-1:0];

  // Config that travels with the beat: fresh on sof, frame config when active,
  // and forced pass-through for stray beats before any frame has started.
  always_comb begin
    beat_mode  = PASS;
    beat_en    = 1'b0;
    beat_level = level;
    if (s_sof) begin
      beat_mode  = mode;
      beat_en    = filter_enable;
      beat_level = sat_level;
    end else if (state_q == ACTIVE) begin
      beat_mode  = cfg_mode;
      beat_en    = cfg_en;
    end
  end

  always_comb begin
    state_d = state_q;
    if (s_fire && s_sof) state_d = ACTIVE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_mode <= PASS;
      cfg_en   <= 1'b0;
      level    <= '0;
    end else if (s_fire && s_sof) begin
      cfg_mode <= mode;
      cfg_en   <= filter_enable;
      level    <= sat_level;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_pix   <= '0;
      s1_mode  <= PASS;
      s1_en    <= 1'b0;
      s1_level <= '0;
    end else if (s_fire) begin
      s1_valid <= 1'b1;
      s1_sof   <= s_sof;
      s1_pix   <= s_pix;
      s1_mode  <= beat_mode;
      s1_en    <= beat_en;
      s1_level <= beat_level;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pixel_filter_lane #(.DATA_W(DATA_W)) u_lane (
      .pix   (s1_pix[c*DATA_W +: DATA_W]),
      .level (s1_level),
      .mode  (s1_mode),
      .en    (s1_en),
      .out   (lane_out[c*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_sof   <= 1'b0;
      m_pix   <= '0;
    end else if (s1_adv) begin
      m_valid <= 1'b1;
      m_sof   <= s1_sof;
      m_pix   <= lane_out;
    end else if (m_fire) begin
      m_valid <= 1'b0;
    end
  end

  // The first output beat of a frame closes the previous frame's count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt     <= '0;
      frame_pixels <= '0;
    end else if (m_fire) begin
      if (m_sof) begin
        frame_pixels <= beat_cnt;
        beat_cnt     <= CNT_W'(1);
      end else if (beat_cnt != {CNT_W{1'b1}}) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bpm_pixel_filter_bank.sv
// Directed bench for bpm_pixel_filter_bank: vector table plus backpressure, saturation and reset sequences.
module tb_bpm_pixel_filter_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] s_pix;
  logic        s_valid;
  logic        s_ready, s_ready9;
  logic        s_sof;
  logic [1:0]  mode;
  logic        filter_enable;
  logic [7:0]  bpm;
  logic [8:0]  bpm9;
  logic [23:0] m_pix, m_pix9;
  logic        m_valid, m_valid9;
  logic        m_ready;
  logic        m_sof, m_sof9;
  logic [7:0]  level, level9;
  logic [31:0] frame_pixels, frame_pixels9;
  logic        frame_state, frame_state9;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_q[$];

  typedef struct {
    logic        sof;
    logic [1:0]  mode;
    logic        en;
    logic [7:0]  bpm;
    logic [23:0] pix;
    logic [23:0] exp_pix;
    logic [7:0]  exp_level;
  } vec_t;

  localparam int N = 12;
  vec_t vec[N];

  always #5 clk = ~clk;

  bpm_pixel_filter_bank #(.DATA_W(8), .CHANNELS(3), .BPM_W(8)) dut (
    .clk(clk), .reset(reset), .s_pix(s_pix), .s_valid(s_valid), .s_ready(s_ready),
    .s_sof(s_sof), .mode(mode), .filter_enable(filter_enable), .bpm_estimate(bpm),
    .m_pix(m_pix), .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof),
    .level(level), .frame_pixels(frame_pixels), .frame_state(frame_state)
  );

  bpm_pixel_filter_bank #(.DATA_W(8), .CHANNELS(3), .BPM_W(9)) dut9 (
    .clk(clk), .reset(reset), .s_pix(s_pix), .s_valid(s_valid), .s_ready(s_ready9),
    .s_sof(s_sof), .mode(mode), .filter_enable(filter_enable), .bpm_estimate(bpm9),
    .m_pix(m_pix9), .m_valid(m_valid9), .m_ready(m_ready), .m_sof(m_sof9),
    .level(level9), .frame_pixels(frame_pixels9), .frame_state(frame_state9)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic sof, input logic [1:0] md, input logic en,
                              input logic [7:0] b, input logic [23:0] p,
                              input logic [23:0] e, input logic [7:0] l);
    vec_t v;
    v.sof = sof; v.mode = md; v.en = en; v.bpm = b;
    v.pix = p; v.exp_pix = e; v.exp_level = l;
    return v;
  endfunction

  function automatic logic [23:0] burst_pix(input logic [7:0] base, input int k);
    logic [7:0] b;
    b = base + 8'(k);
    return {b, b + 8'd1, b + 8'd2};
  endfunction

  task automatic drive(input logic v, input logic sof, input logic [1:0] md, input logic en,
                       input logic [7:0] b, input logic [23:0] p);
    s_valid = v; s_sof = sof; mode = md; filter_enable = en;
    bpm = b; bpm9 = {1'b0, b}; s_pix = p;
  endtask

  // Streams 10 pass-mode beats as one frame, optionally stalling m_ready for 5 cycles.
  task automatic run_burst(input int stall_at, input logic [7:0] base);
    int sent = 0;
    int got = 0;
    logic hold_chk = 1'b0;
    logic [23:0] held = '0;
    logic [23:0] exp;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      m_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
      drive(sent < 10, sent == 0, 2'd0, 1'b0, 8'd0, burst_pix(base, sent));
      #1;
      if (hold_chk) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_pix", 32'(m_pix), 32'(held));
      end
      if (stall_at >= 0 && cyc == stall_at + 1) check("stall_s_ready", 32'(s_ready), 32'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("burst_extra_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          exp = exp_q.pop_front();
          check("burst_pix", 32'(m_pix), 32'(exp));
          check("burst_sof", 32'(m_sof), 32'(got == 0));
        end
        got++;
      end
      hold_chk = m_valid && !m_ready;
      held = m_pix;
      if (s_valid && s_ready) begin
        exp_q.push_back(s_pix);
        sent++;
      end
      step();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check("burst_count", 32'(got), 32'd10);
    check("burst_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    m_ready = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 24'd0);

    vec[0]  = mk(0, 2'd3, 1, 8'd77,  24'h010203, 24'h010203, 8'd0);
    vec[1]  = mk(1, 2'd1, 1, 8'd200, 24'hffffff, 24'hffffff, 8'd200);
    vec[2]  = mk(0, 2'd2, 0, 8'd56,  24'he6e6e6, 24'hffffff, 8'd200);
    vec[3]  = mk(0, 2'd2, 0, 8'd56,  24'hcdcdcd, 24'hffffff, 8'd200);
    vec[4]  = mk(0, 2'd1, 1, 8'd56,  24'hb4b4b4, 24'h000000, 8'd200);
    vec[5]  = mk(0, 2'd0, 1, 8'd56,  24'hb4c8c7, 24'h00ff00, 8'd200);
    vec[6]  = mk(1, 2'd2, 1, 8'd56,  24'hffffff, 24'h9b9b9b, 8'd56);
    vec[7]  = mk(0, 2'd3, 1, 8'd200, 24'h006438, 24'h1c4e38, 8'd56);
    vec[8]  = mk(1, 2'd3, 1, 8'd10,  24'h00ff5a, 24'hff00a5, 8'd10);
    vec[9]  = mk(1, 2'd1, 0, 8'd99,  24'h010203, 24'h010203, 8'd99);
    vec[10] = mk(1, 2'd0, 1, 8'd42,  24'h090807, 24'h090807, 8'd42);
    vec[11] = mk(0, 2'd3, 1, 8'd42,  24'h102030, 24'h102030, 8'd42);

    #12;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_pix", 32'(m_pix), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_frame_pixels", frame_pixels, 32'd0);
    check("rst_state", 32'(frame_state), 32'd0);
    reset = 1'b1;
    step();

    // Beat i is driven, accepted at the next edge, and visible one edge later.
    for (int i = 0; i <= N; i++) begin
      if (i < N) drive(1'b1, vec[i].sof, vec[i].mode, vec[i].en, vec[i].bpm, vec[i].pix);
      else       drive(1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 24'd0);
      step();
      if (i < N) check($sformatf("level_%0d", i), 32'(level), 32'(vec[i].exp_level));
      if (i >= 1) begin
        check($sformatf("valid_%0d", i - 1), 32'(m_valid), 32'd1);
        check($sformatf("pix_%0d", i - 1), 32'(m_pix), 32'(vec[i-1].exp_pix));
        check($sformatf("sof_%0d", i - 1), 32'(m_sof), 32'(vec[i-1].sof));
      end
    end
    step();
    check("drained_valid", 32'(m_valid), 32'd0);

    drive(1'b1, 1'b1, 2'd2, 1'b1, 8'd56, 24'hffffff);
    bpm9 = 9'd300;
    step();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 24'd0);
    check("sat_level9", 32'(level9), 32'd255);
    check("blend_level8", 32'(level), 32'd56);
    step();
    check("sat_valid9", 32'(m_valid9), 32'd1);
    check("sat_pix9", 32'(m_pix9), 32'hffffff);
    check("blend_pix8", 32'(m_pix), 32'h9b9b9b);
    step();

    run_burst(3, 8'h20);
    check("frame_pixels_after_f1", frame_pixels, 32'd1);
    run_burst(-1, 8'h80);
    check("frame_pixels_after_f2", frame_pixels, 32'd10);
    check("state_active", 32'(frame_state), 32'd1);

    drive(1'b1, 1'b1, 2'd1, 1'b1, 8'd200, 24'h112233);
    step();
    drive(1'b1, 1'b0, 2'd1, 1'b1, 8'd200, 24'h445566);
    step();
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    check("pre_rst_level", 32'(level), 32'd200);
    reset = 1'b0;
    #1;
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_frame_pixels", frame_pixels, 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    check("midrst_m_pix", 32'(m_pix), 32'd0);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 24'd0);
    step();
    reset = 1'b1;
    step();
    step();
    check("post_rst_no_beat", 32'(m_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
